wbvio_burst_bridge: RTL and testbench
=====================================

Name: wbvio_burst_bridge

Overview:
Parametrised successor of the single-shot VIO-to-WISHBONE bridge. A debug/VIO-style control port starts a WISHBONE master transaction on a rising edge of go. Each transaction is 1..MAX_BURST beats, with optional address auto-increment, byte selects, bounded retry on rty, a per-beat watchdog timeout and bus lock. Read beats are captured into a small indexed buffer that the control side reads back; it sits between the VIO core and the board WISHBONE interconnect.

Parameters:
DW, 32, data width (multiple of 8)
AW, 20, address width
MAX_BURST, 16, max beats per transaction (power of 2, >=2); LW = log2(MAX_BURST)
ADDR_STEP, 1, address increment per beat when incrementing
RETRY_MAX, 3, rty re-issues per beat before failing
TIMEOUT, 1023, cycles without ack/err/rty before abort (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ctl_dat_i  in  DW  write data (same word written every beat: fill)
ctl_adr_i  in  AW  start address
ctl_sel_i  in  DW/8  byte selects
ctl_we_i  in  1  1=write, 0=read
ctl_len_i  in  LW  beats minus 1
ctl_incr_i  in  1  1=auto-increment address
ctl_go_i  in  1  start on rising edge; level acknowledges done
ctl_lock_i  in  1  hold cyc between transactions
ctl_idx_i  in  LW  read-buffer index
ctl_dat_o  out  DW  read buffer word at ctl_idx_i (combinational)
ctl_cnt_o  out  LW+1  beats completed in last/current transaction
ctl_busy_o  out  1  transaction in progress
ctl_done_o  out  1  transaction finished (ok or error)
ctl_err_o  out  1  finished with err_i or retries exhausted
ctl_tmo_o  out  1  finished by timeout
dat_o adr_o sel_o cyc_o stb_o we_o  out  DW/AW/DW/8/1/1/1  WISHBONE master
dat_i ack_i err_i rty_i  in  DW/1/1/1  WISHBONE slave response

Behaviour:
- Reset (async): state IDLE; cyc/stb/we/busy/done/err/tmo/cnt = 0; adr_o/dat_o/sel_o = 0; go_q = 0; buffer contents undefined.
- go_rise = ctl_go_i & ~go_q. go_q is registered every cycle.
- IDLE: on go_rise, capture dat/adr/sel/we/len/incr. Clear cnt/err/tmo and set beat=0, retry=0, tmo_cnt=0. Go to ACCESS. cyc, stb and busy are 1 in the next cycle (latency 1).
- ACCESS: stb=1, cyc=1. Response priority per edge: err_i > rty_i > ack_i > timeout.
  - ack_i: for a read, write dat_i to buf[beat]. Increment cnt. If beat==len, go to DONE. Otherwise beat++, adr_o += ADDR_STEP if incr, retry=0, tmo_cnt=0, and stb stays high (back-to-back beats).
  - err_i: go to DONE with err=1.
  - rty_i: if retry<RETRY_MAX, retry++ and go to RETRY. Otherwise go to DONE with err=1.
  - No response: tmo_cnt++. At tmo_cnt==TIMEOUT-1 with no response, go to DONE with tmo=1 and err=1.
- RETRY: exactly one cycle with stb=0 and cyc held; tmo_cnt=0; return to ACCESS.
- Leaving ACCESS to DONE: stb=0 next cycle. cyc=0 next cycle unless ctl_lock_i.
- DONE: done=1, busy=0. Exit to IDLE on the first cycle ctl_go_i==0. If go already dropped mid-transfer, done is high for exactly one cycle. err/tmo/cnt and the buffer hold until the next go_rise.
- go_rise while not IDLE: ignored. Capture registers do not change.
- cyc in IDLE/DONE = ctl_lock_i, registered. Lock deassertion drops cyc the next cycle. A lock change in ACCESS/RETRY has no effect until the transaction ends.
- Address arithmetic wraps modulo 2^AW, no error.
- len=0 gives a single beat. cnt reaches len+1 on success.
- ack/err/rty while stb=0 (IDLE, RETRY, DONE): ignored.
- Reset mid-burst: cyc/stb drop asynchronously, no done pulse.

Decomposition:
- Package wbvio_pkg: state encoding constants (IDLE, ACCESS, RETRY, DONE); clog2 function; response-priority constant ordering.
- One sub-module, wbvio_rdbuf: MAX_BURST x DW register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port (ctl_idx_i). Keeping the buffer separate lets it map to distributed RAM.

Test Plan:
- Single read: len=0, adr=0x00010, go 0->1; slave acks 2 cycles after stb with 0xDEADBEEF. Expect cyc/stb high 1 cycle after go, ctl_dat_o[0]=0xDEADBEEF, done=1, err=0, cnt=1, cyc=0 after. Go low drops done.
- Write burst: len=3, incr=1, adr=0x00100, dat=0xA5A5A5A5, sel=0xF; zero-wait ack. Expect adr_o 0x100,0x101,0x102,0x103 on consecutive cycles with stb continuous, 4 write acks, cnt=4.
- Retry: single read; slave asserts rty twice, then ack. Expect stb low one cycle after each rty, 3 strobes total, done=1, err=0. With 4 rty (RETRY_MAX=3), expect err=1 and cnt=0.
- Timeout: TIMEOUT=16, no slave response. Expect stb drop 16 cycles after assertion, tmo=1, err=1, done=1.
- Lock: lock=1 then two reads. Expect cyc high continuously across both transactions and dropping 1 cycle after lock=0.
- Reset mid-burst: assert rst_i during beat 2 of a len=7 read. Expect cyc/stb/busy=0 immediately, done=0. A subsequent go works normally.

Source files
------------

// File: rtl/wbvio_pkg.sv
// Shared definitions for the burst-capable VIO-to-WISHBONE bridge.
//
// Contents:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - Slave response classes, ordered so that a higher code wins
//   - clog2 helper for sizing counters and indices
//   - resp_decode: collapses err/rty/ack into one prioritised class
package wbvio_pkg;

    // Bridge FSM states
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StRetry  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Response classes; numeric order is priority order (err > rty > ack > none).
    // A missing response feeds the watchdog instead.
    localparam logic [1:0] RespNone = 2'd0;
    localparam logic [1:0] RespAck  = 2'd1;
    localparam logic [1:0] RespRty  = 2'd2;
    localparam logic [1:0] RespErr  = 2'd3;

    // Smallest width w such that 2**w >= value (0 for value <= 1)
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // Several response lines may be raised on the same edge; only the strongest counts.
    function automatic logic [1:0] resp_decode(input logic err, input logic rty,
                                               input logic ack);
        logic [1:0] resp;
        if (err) begin
            resp = RespErr;
        end else if (rty) begin
            resp = RespRty;
        end else if (ack) begin
            resp = RespAck;
        end else begin
            resp = RespNone;
        end
        return resp;
    endfunction

endpackage

// File: rtl/wbvio_rdbuf.sv
// Read-capture buffer for the burst bridge.
//
// DEPTH x DW register file with one synchronous write port and one
// asynchronous read port. No reset: contents are undefined until written,
// which keeps the array mappable onto distributed RAM.
//
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   raddr_i  read index (combinational read)
//   rdata_o  word stored at raddr_i
module wbvio_rdbuf
    import wbvio_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IW   = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wbvio_burst_bridge.sv
// VIO-style control port to WISHBONE master bridge with bursts.
//
// A rising edge on ctl_go_i launches a 1..MAX_BURST beat transaction using
// the captured address/data/select/direction. Read beats land in a small
// indexed buffer that the control side reads back through ctl_idx_i.
// Each beat may be re-issued on rty up to RETRY_MAX times, and is aborted
// by a watchdog after TIMEOUT cycles without any slave response.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   ctl_dat_i              write data (same word on every beat)
//   ctl_adr_i, ctl_sel_i   start address, byte selects
//   ctl_we_i, ctl_len_i    direction, beats minus one
//   ctl_incr_i             advance address by ADDR_STEP per beat
//   ctl_go_i               rising edge starts; low level leaves DONE
//   ctl_lock_i             keep cyc_o asserted between transactions
//   ctl_idx_i, ctl_dat_o   read-buffer index and word (combinational)
//   ctl_cnt_o              beats completed in the last/current transaction
//   ctl_busy_o/done_o      in progress / finished
//   ctl_err_o/tmo_o        finished with error / by watchdog
//   dat_o..we_o            WISHBONE master outputs
//   dat_i, ack_i, err_i, rty_i  WISHBONE slave response
module wbvio_burst_bridge
    import wbvio_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 20,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ADDR_STEP = 1,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 1023,
    localparam int unsigned LW       = clog2(MAX_BURST)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // Control side
    input  logic [DW-1:0]   ctl_dat_i,
    input  logic [AW-1:0]   ctl_adr_i,
    input  logic [DW/8-1:0] ctl_sel_i,
    input  logic            ctl_we_i,
    input  logic [LW-1:0]   ctl_len_i,
    input  logic            ctl_incr_i,
    input  logic            ctl_go_i,
    input  logic            ctl_lock_i,
    input  logic [LW-1:0]   ctl_idx_i,
    output logic [DW-1:0]   ctl_dat_o,
    output logic [LW:0]     ctl_cnt_o,
    output logic            ctl_busy_o,
    output logic            ctl_done_o,
    output logic            ctl_err_o,
    output logic            ctl_tmo_o,
    // WISHBONE master
    output logic [DW-1:0]   dat_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW/8-1:0] sel_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            rty_i
);

    localparam int unsigned CW = LW + 1;
    // +2 keeps the counter at least one bit wide even when RETRY_MAX is 0
    localparam int unsigned RW = clog2(RETRY_MAX + 2);
    localparam int unsigned TW = clog2(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic            go_q;
    logic            cyc_q, cyc_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic            we_q, we_d;
    logic [LW-1:0]   len_q, len_d;
    logic            incr_q, incr_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            tmo_q, tmo_d;

    logic            go_rise;
    logic [1:0]      resp;
    logic            buf_we;

    assign go_rise = ctl_go_i & ~go_q;
    assign resp    = resp_decode(err_i, rty_i, ack_i);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        len_d     = len_q;
        incr_d    = incr_q;
        beat_d    = beat_q;
        retry_d   = retry_q;
        tmo_cnt_d = tmo_cnt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        buf_we    = 1'b0;

        case (state_q)
            StIdle: begin
                // Outside a transaction cyc simply follows the lock request
                cyc_d = ctl_lock_i;
                if (go_rise) begin
                    adr_d     = ctl_adr_i;
                    dat_d     = ctl_dat_i;
                    sel_d     = ctl_sel_i;
                    we_d      = ctl_we_i;
                    len_d     = ctl_len_i;
                    incr_d    = ctl_incr_i;
                    beat_d    = '0;
                    retry_d   = '0;
                    tmo_cnt_d = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    cyc_d     = 1'b1;
                    state_d   = StAccess;
                end
            end

            StAccess: begin
                case (resp)
                    RespErr: begin
                        err_d   = 1'b1;
                        cyc_d   = ctl_lock_i;
                        state_d = StDone;
                    end
                    RespRty: begin
                        if (retry_q < RW'(RETRY_MAX)) begin
                            retry_d = retry_q + RW'(1);
                            state_d = StRetry;
                        end else begin
                            err_d   = 1'b1;
                            cyc_d   = ctl_lock_i;
                            state_d = StDone;
                        end
                    end
                    RespAck: begin
                        buf_we = ~we_q;
                        cnt_d  = cnt_q + CW'(1);
                        if (beat_q == len_q) begin
                            cyc_d   = ctl_lock_i;
                            state_d = StDone;
                        end else begin
                            // Stay in ACCESS so stb remains high for the next beat
                            beat_d    = beat_q + LW'(1);
                            retry_d   = '0;
                            tmo_cnt_d = '0;
                            if (incr_q) begin
                                adr_d = adr_q + AW'(ADDR_STEP);
                            end
                        end
                    end
                    default: begin
                        if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                            err_d   = 1'b1;
                            tmo_d   = 1'b1;
                            cyc_d   = ctl_lock_i;
                            state_d = StDone;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TW'(1);
                        end
                    end
                endcase
            end

            StRetry: begin
                // One idle strobe cycle with cyc held, then re-issue the same beat
                tmo_cnt_d = '0;
                state_d   = StAccess;
            end

            default: begin
                // StDone: results hold until the next go edge
                cyc_d = ctl_lock_i;
                if (!ctl_go_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            go_q      <= 1'b0;
            cyc_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            len_q     <= '0;
            incr_q    <= 1'b0;
            beat_q    <= '0;
            retry_q   <= '0;
            tmo_cnt_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= ctl_go_i;
            cyc_q     <= cyc_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            len_q     <= len_d;
            incr_q    <= incr_d;
            beat_q    <= beat_d;
            retry_q   <= retry_d;
            tmo_cnt_q <= tmo_cnt_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    wbvio_rdbuf #(
        .DW    (DW),
        .DEPTH (MAX_BURST)
    ) u_rdbuf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (beat_q),
        .wdata_i (dat_i),
        .raddr_i (ctl_idx_i),
        .rdata_o (ctl_dat_o)
    );

    // Strobe, busy and done decode straight from the registered state
    assign stb_o      = (state_q == StAccess);
    assign cyc_o      = cyc_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign sel_o      = sel_q;
    assign ctl_busy_o = (state_q == StAccess) || (state_q == StRetry);
    assign ctl_done_o = (state_q == StDone);
    assign ctl_cnt_o  = cnt_q;
    assign ctl_err_o  = err_q;
    assign ctl_tmo_o  = tmo_q;

endmodule

// File: tb/tb_wbvio_burst_bridge.sv
// Self-checking bench for wbvio_burst_bridge (TIMEOUT overridden to 16).
module tb_wbvio_burst_bridge;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 20;
    localparam int unsigned LW  = 4;
    localparam int unsigned TMO = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [DW-1:0]   ctl_dat_i = '0;
    logic [AW-1:0]   ctl_adr_i = '0;
    logic [3:0]      ctl_sel_i = '0;
    logic            ctl_we_i = 1'b0;
    logic [LW-1:0]   ctl_len_i = '0;
    logic            ctl_incr_i = 1'b0;
    logic            ctl_go_i = 1'b0;
    logic            ctl_lock_i = 1'b0;
    logic [LW-1:0]   ctl_idx_i = '0;
    logic [DW-1:0]   ctl_dat_o;
    logic [LW:0]     ctl_cnt_o;
    logic            ctl_busy_o, ctl_done_o, ctl_err_o, ctl_tmo_o;
    logic [DW-1:0]   dat_o;
    logic [AW-1:0]   adr_o;
    logic [3:0]      sel_o;
    logic            cyc_o, stb_o, we_o;
    logic [DW-1:0]   dat_i = '0;
    logic            ack_i = 1'b0;
    logic            err_i = 1'b0;
    logic            rty_i = 1'b0;

    always #5 clk_i = ~clk_i;

    wbvio_burst_bridge #(
        .TIMEOUT (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ctl_dat_i  (ctl_dat_i),
        .ctl_adr_i  (ctl_adr_i),
        .ctl_sel_i  (ctl_sel_i),
        .ctl_we_i   (ctl_we_i),
        .ctl_len_i  (ctl_len_i),
        .ctl_incr_i (ctl_incr_i),
        .ctl_go_i   (ctl_go_i),
        .ctl_lock_i (ctl_lock_i),
        .ctl_idx_i  (ctl_idx_i),
        .ctl_dat_o  (ctl_dat_o),
        .ctl_cnt_o  (ctl_cnt_o),
        .ctl_busy_o (ctl_busy_o),
        .ctl_done_o (ctl_done_o),
        .ctl_err_o  (ctl_err_o),
        .ctl_tmo_o  (ctl_tmo_o),
        .dat_o      (dat_o),
        .adr_o      (adr_o),
        .sel_o      (sel_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .dat_i      (dat_i),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .rty_i      (rty_i)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [3:0]    sel;
        logic [31:0]   dat;
        logic [3:0]    len;
        logic          incr;
        int            wt;        // slave wait cycles before each response
        int            rtys;      // rty responses before the slave acks
        logic          serr;      // slave answers err
        logic          mute;      // slave never answers
        logic          early;     // drop go right after the start
        logic [31:0]   rbase;     // read data = rbase + beat number
        logic [4:0]    exp_cnt;
        logic          exp_err;
        logic          exp_tmo;
        int            exp_rises; // separate strobe assertions
        int            exp_hi;    // total cycles with stb high
    } vec_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [3:0]    sel;
        logic [31:0]   dat;
    } beat_t;

    beat_t exp_q[$];
    beat_t sb_e;
    vec_t  tbl[10];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model and bus monitor, evaluated on the falling edge
    int          slv_wait = 0;
    int          slv_rty = 0;
    int          wcnt = 0;
    int          slv_beat = 0;
    int          rises = 0;
    int          hi_cnt = 0;
    int          cyc_low = 0;
    logic        slv_err = 1'b0;
    logic        slv_mute = 1'b0;
    logic        stb_prev = 1'b0;
    logic        cyc_watch = 1'b0;
    logic [31:0] slv_base = '0;

    always @(negedge clk_i) begin
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        if (stb_o && !stb_prev) rises++;
        if (stb_o) hi_cnt++;
        if (cyc_watch && !cyc_o) cyc_low++;
        stb_prev = stb_o;
        if (stb_o) begin
            if (wcnt < slv_wait) begin
                wcnt++;
            end else if (slv_mute) begin
                wcnt = wcnt;
            end else if (slv_err) begin
                err_i = 1'b1;
            end else if (slv_rty > 0) begin
                rty_i = 1'b1;
                slv_rty--;
                wcnt = 0;
            end else begin
                ack_i = 1'b1;
                dat_i = slv_base + 32'(slv_beat);
                slv_beat++;
                wcnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got adr 0x%0h expected no beat", adr_o);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("beat_adr", 64'(adr_o), 64'(sb_e.adr));
                    check("beat_we", 64'(we_o), 64'(sb_e.we));
                    check("beat_sel", 64'(sel_o), 64'(sb_e.sel));
                    if (sb_e.we) check("beat_dat", 64'(dat_o), 64'(sb_e.dat));
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic run_row(input vec_t v, input string tag);
        logic [AW-1:0] a;
        int n;
        slv_wait = v.wt;
        slv_rty  = v.rtys;
        slv_err  = v.serr;
        slv_mute = v.mute;
        slv_base = v.rbase;
        slv_beat = 0;
        wcnt     = 0;
        rises    = 0;
        hi_cnt   = 0;
        a = v.adr;
        for (int i = 0; i < int'(v.exp_cnt); i++) begin
            exp_q.push_back('{a, v.we, v.sel, v.dat});
            if (v.incr) a = a + 1'b1;
        end
        ctl_we_i   = v.we;
        ctl_adr_i  = v.adr;
        ctl_sel_i  = v.sel;
        ctl_dat_i  = v.dat;
        ctl_len_i  = v.len;
        ctl_incr_i = v.incr;
        ctl_go_i   = 1'b1;
        @(posedge clk_i); #1;
        check({tag, "_start_cyc_stb_busy_done"},
              64'({cyc_o, stb_o, ctl_busy_o, ctl_done_o}), 64'(4'b1110));
        if (v.early) ctl_go_i = 1'b0;
        n = 0;
        while (!ctl_done_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_done"}, 64'(ctl_done_o), 64'(1));
        check({tag, "_err"}, 64'(ctl_err_o), 64'(v.exp_err));
        check({tag, "_tmo"}, 64'(ctl_tmo_o), 64'(v.exp_tmo));
        check({tag, "_cnt"}, 64'(ctl_cnt_o), 64'(v.exp_cnt));
        check({tag, "_stb_busy_idle"}, 64'({stb_o, ctl_busy_o}), 64'(0));
        check({tag, "_cyc_after"}, 64'(cyc_o), 64'(ctl_lock_i));
        check({tag, "_stb_rises"}, 64'(rises), 64'(v.exp_rises));
        if (v.exp_hi != 0) check({tag, "_stb_cycles"}, 64'(hi_cnt), 64'(v.exp_hi));
        check({tag, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        if (!v.we && !v.exp_err) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                ctl_idx_i = 4'(i);
                #1;
                check({tag, "_rdbuf"}, 64'(ctl_dat_o), 64'(v.rbase + 32'(i)));
            end
        end
        ctl_go_i = 1'b0;
        @(posedge clk_i); #1;
        check({tag, "_done_clear"}, 64'(ctl_done_o), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        //          we    adr          sel   dat           len   incr wt rty serr  mute  early rbase         cnt   err   tmo  rise hi
        tbl[0] = '{1'b0, 20'h00010, 4'hF, 32'h0,        4'd0,  1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd1,  1'b0, 1'b0, 1, 3};
        tbl[1] = '{1'b1, 20'h00100, 4'hF, 32'hA5A5A5A5, 4'd3,  1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4,  1'b0, 1'b0, 1, 4};
        tbl[2] = '{1'b0, 20'h00020, 4'hF, 32'h0,        4'd0,  1'b0, 0, 2, 1'b0, 1'b0, 1'b0, 32'h12345678, 5'd1,  1'b0, 1'b0, 3, 3};
        tbl[3] = '{1'b0, 20'h00020, 4'hF, 32'h0,        4'd0,  1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  1'b1, 1'b0, 4, 4};
        tbl[4] = '{1'b0, 20'hFFFFE, 4'hC, 32'h0,        4'd3,  1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h00001000, 5'd4,  1'b0, 1'b0, 1, 4};
        tbl[5] = '{1'b1, 20'h00200, 4'h3, 32'h0BADF00D, 4'd15, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd16, 1'b0, 1'b0, 1, 32};
        tbl[6] = '{1'b0, 20'h00300, 4'hF, 32'h0,        4'd2,  1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 32'hCAFE0000, 5'd3,  1'b0, 1'b0, 1, 3};
        tbl[7] = '{1'b0, 20'h00040, 4'hF, 32'h0,        4'd1,  1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0,  1'b1, 1'b0, 1, 2};
        tbl[8] = '{1'b0, 20'h00050, 4'hF, 32'h0,        4'd0,  1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0,  1'b1, 1'b1, 1, 16};
        tbl[9] = '{1'b0, 20'h00060, 4'hF, 32'h0,        4'd1,  1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 32'h00000055, 5'd2,  1'b0, 1'b0, 1, 8};

        // Reset state
        #12;
        check("reset_ctl", 64'({ctl_busy_o, ctl_done_o, ctl_err_o, ctl_tmo_o, ctl_cnt_o}), 64'(0));
        check("reset_bus", 64'({cyc_o, stb_o, we_o, sel_o}), 64'(0));
        check("reset_adr_dat", 64'({adr_o, dat_o}), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int r = 0; r < 10; r++) begin
            run_row(tbl[r], $sformatf("row%0d", r));
        end

        // Reset during beat 2 of an 8-beat incrementing read
        slv_wait = 0; slv_rty = 0; slv_err = 1'b0; slv_mute = 1'b0;
        slv_base = 32'h77; slv_beat = 0; wcnt = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back('{20'h00400 + 20'(i), 1'b0, 4'hF, 32'h0});
        ctl_we_i = 1'b0; ctl_adr_i = 20'h00400; ctl_sel_i = 4'hF; ctl_len_i = 4'd7;
        ctl_incr_i = 1'b1; ctl_go_i = 1'b1;
        n = 0;
        while (slv_beat < 2 && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("rst_mid_reached_beat2", 64'(slv_beat), 64'(2));
        check("rst_mid_busy_before", 64'(ctl_busy_o), 64'(1));
        rst_i = 1'b1;
        ctl_go_i = 1'b0;
        #1;
        check("rst_mid_async", 64'({cyc_o, stb_o, ctl_busy_o, ctl_done_o}), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(posedge clk_i); #1;
        check("rst_mid_no_done", 64'({ctl_done_o, ctl_busy_o, cyc_o}), 64'(0));
        run_row(tbl[0], "after_rst");

        // Lock holds cyc across two transactions, then drops one cycle after release
        ctl_lock_i = 1'b1;
        @(posedge clk_i); #1;
        check("lock_idle_cyc_stb", 64'({cyc_o, stb_o}), 64'(2'b10));
        cyc_low = 0;
        cyc_watch = 1'b1;
        run_row(tbl[0], "lock_a");
        run_row(tbl[6], "lock_b");
        cyc_watch = 1'b0;
        check("lock_cyc_never_low", 64'(cyc_low), 64'(0));
        ctl_lock_i = 1'b0;
        @(posedge clk_i); #1;
        check("lock_release_cyc", 64'(cyc_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
